// File: rtl/disp_hex_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with per-frame input capture.
// Optional build macro DISP_LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module disp_hex_mux #(
  parameter int unsigned REFRESH_DIV = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex0,
  input  logic [3:0] hex1,
  input  logic [3:0] hex2,
  input  logic [3:0] hex3,
  input  logic [3:0] dp_in,
  input  logic [3:0] blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    idx;
  logic [3:0]    snap_hex0, snap_hex1, snap_hex2, snap_hex3;
  logic [3:0]    snap_dp, snap_blank;
  logic          snap_valid;

  logic [3:0]    cur_hex;
  logic          cur_dark;
  logic          lz_dark;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd3;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Capture on the tick that wraps the index to 0; snap_valid keeps the
  // display dark until the first real frame exists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_hex0  <= '0;
      snap_hex1  <= '0;
      snap_hex2  <= '0;
      snap_hex3  <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
      snap_valid <= 1'b0;
    end else if (tick && idx == 2'd3) begin
      snap_hex0  <= hex0;
      snap_hex1  <= hex1;
      snap_hex2  <= hex2;
      snap_hex3  <= hex3;
      snap_dp    <= dp_in;
      snap_blank <= blank;
      snap_valid <= 1'b1;
    end
  end

  always_comb begin
    cur_hex = snap_hex0;
    lz_dark = 1'b0;
    case (idx)
      2'd0: cur_hex = snap_hex0;
      2'd1: cur_hex = snap_hex1;
      2'd2: cur_hex = snap_hex2;
      default: cur_hex = snap_hex3;
    endcase
`ifdef DISP_LEADING_ZERO_BLANK_EN
    case (idx)
      2'd3: lz_dark = (snap_hex3 == 4'h0);
      2'd2: lz_dark = (snap_hex3 == 4'h0) && (snap_hex2 == 4'h0);
      2'd1: lz_dark = (snap_hex3 == 4'h0) && (snap_hex2 == 4'h0) && (snap_hex1 == 4'h0);
      default: lz_dark = 1'b0;
    endcase
`endif
    cur_dark = !snap_valid || snap_blank[idx] || lz_dark;

    an_nxt  = '1;
    seg_nxt = '1;
    dp_nxt  = 1'b1;
    if (!cur_dark) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = decode(cur_hex);
      dp_nxt  = ~snap_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_disp_hex_mux.sv
// Directed self-checking bench for disp_hex_mux with REFRESH_DIV=4.
module tb_disp_hex_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hex0 = '0, hex1 = '0, hex2 = '0, hex3 = '0;
  logic [3:0] dp_in = '0, blank = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;

  disp_hex_mux #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .dp_in(dp_in), .blank(blank),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    tests++;
    assert ({an, seg, dp} === {ea, es, ed}) else begin
      fails++;
      $error("FAIL %s: an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b", tag, an, seg, dp, ea, es, ed);
    end
  endtask

  initial begin
    hex3 = 4'h1; hex2 = 4'h2; hex1 = 4'h3; hex0 = 4'h4;
    dp_in = 4'b0100; blank = 4'b0000;
    adv(2);
    chk("reset_state", 4'b1111, 7'b1111111, 1'b1);

    @(negedge clk) rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      adv(1);
      chk($sformatf("dark_after_release_%0d", i), 4'b1111, 7'b1111111, 1'b1);
    end
    adv(1);  // edge 5
    chk("first_slot0", 4'b1110, 7'b0011001, 1'b1);
    adv(3);  // edge 8
    chk("slot0_held", 4'b1110, 7'b0011001, 1'b1);
    adv(1);  // edge 9
    chk("slot1", 4'b1101, 7'b0110000, 1'b1);
    adv(4);  // edge 13
    chk("slot2_dp", 4'b1011, 7'b0100100, 1'b0);
    hex0 = 4'h9;
    adv(4);  // edge 17
    chk("slot3", 4'b0111, 7'b1111001, 1'b1);
    adv(4);  // edge 21
    chk("next_frame_slot0", 4'b1110, 7'b0010000, 1'b1);
    blank = 4'b1000; hex3 = 4'h8;
    adv(4);  // edge 25
    chk("slot1_frame2", 4'b1101, 7'b0110000, 1'b1);
    adv(8);  // edge 33
    chk("slot3_midframe_hold", 4'b0111, 7'b1111001, 1'b1);
    adv(4);  // edge 37
    chk("slot0_frame3", 4'b1110, 7'b0010000, 1'b1);
    adv(8);  // edge 45
    chk("slot2_blank_frame", 4'b1011, 7'b0100100, 1'b0);
    adv(4);  // edge 49
    chk("slot3_blanked", 4'b1111, 7'b1111111, 1'b1);

    hex3 = 4'h0; hex2 = 4'h0; hex1 = 4'h0; hex0 = 4'h7;
    blank = 4'b0000; dp_in = 4'b0000;
    adv(4);  // edge 53
    chk("lz_slot0", 4'b1110, 7'b1111000, 1'b1);
`ifdef DISP_LEADING_ZERO_BLANK_EN
    adv(4); chk("lz_slot1_dark", 4'b1111, 7'b1111111, 1'b1);
    adv(4); chk("lz_slot2_dark", 4'b1111, 7'b1111111, 1'b1);
    adv(4); chk("lz_slot3_dark", 4'b1111, 7'b1111111, 1'b1);
`else
    adv(4); chk("zero_slot1", 4'b1101, 7'b1000000, 1'b1);
    adv(4); chk("zero_slot2", 4'b1011, 7'b1000000, 1'b1);
    adv(4); chk("zero_slot3", 4'b0111, 7'b1000000, 1'b1);
`endif

    hex3 = 4'hA; hex2 = 4'hB; hex1 = 4'hC; hex0 = 4'hD;
    adv(4);  // edge 69
    chk("hex_d_slot0", 4'b1110, 7'b0100001, 1'b1);
    adv(4);  // edge 73
    chk("hex_c_slot1", 4'b1101, 7'b1000110, 1'b1);
    #2;
    rst = 1'b0; hex0 = 4'h6;
    #1;
    chk("async_reset_dark", 4'b1111, 7'b1111111, 1'b1);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    adv(4);
    chk("restart_dark_edge4", 4'b1111, 7'b1111111, 1'b1);
    adv(1);
    chk("restart_slot0_fresh", 4'b1110, 7'b0000010, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
